// File: rtl/seq_detector_param_if.sv
// Serial bit-sequence detector bus: bit stream, pattern reload,
// counter clear (master side) and match pulse / counter (slave side).
//   in, en          : serial bit and its valid qualifier
//   pat_load, pat_in: runtime pattern reload
//   clr_cnt         : synchronous clear of the match counter
//   out             : registered one-cycle match pulse
//   match_cnt       : saturating match count
//   cnt_sat         : match_cnt is all-ones
interface seq_detector_param_if #(
    parameter int unsigned PAT_W = 6,
    parameter int unsigned CNT_W = 8
);
    logic             in;
    logic             en;
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
    logic             clr_cnt;
    logic             out;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;

    modport master (
        output in, en, pat_load, pat_in, clr_cnt,
        input  out, match_cnt, cnt_sat
    );

    modport slave (
        input  in, en, pat_load, pat_in, clr_cnt,
        output out, match_cnt, cnt_sat
    );
endinterface

// File: rtl/seq_detector_param.sv
// Parameterised serial bit-sequence detector with runtime pattern
// reload, input-valid qualifier and a saturating match counter.
//   clk   : system clock, rising edge
//   reset : asynchronous active-high, clears all state
//   bus   : seq_detector_param_if slave (stream in, pulse/count out)
module seq_detector_param #(
    parameter int unsigned      PAT_W   = 6,
    parameter logic [PAT_W-1:0] PATTERN = 6'b110011,
    parameter bit               OVERLAP = 1'b1,
    parameter int unsigned      CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    seq_detector_param_if.slave  bus
);
    localparam int unsigned FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);

    logic [PAT_W-1:0] r_pat;
    logic [PAT_W-1:0] r_hist;
    logic [FW-1:0]    r_fill;
    logic             r_out;
    logic [CNT_W-1:0] r_cnt;

    logic [PAT_W-1:0] w_hist_n;
    logic [FW-1:0]    w_fill_n;
    logic             w_match;
    logic             w_cnt_max;

    // r_fill counts valid bits since the last restart; it gates the
    // compare so zero-filled history cannot match an all-zero pattern.
    always_comb begin
        w_hist_n  = {r_hist[PAT_W-2:0], bus.in};
        w_fill_n  = (r_fill == FULL) ? FULL : r_fill + 1'b1;
        w_match   = bus.en && !bus.pat_load &&
                    (w_fill_n == FULL) && (w_hist_n == r_pat);
        w_cnt_max = &r_cnt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pat  <= PATTERN;
            r_hist <= '0;
            r_fill <= '0;
        end else if (bus.pat_load) begin
            r_pat  <= bus.pat_in;
            r_hist <= '0;
            r_fill <= '0;
        end else if (bus.en) begin
            r_hist <= w_hist_n;
            r_fill <= (w_match && !OVERLAP) ? '0 : w_fill_n;
        end
    end

    // w_match is already low on load and idle cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out <= 1'b0;
        end else begin
            r_out <= w_match;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (bus.clr_cnt) begin
            r_cnt <= '0;
        end else if (w_match && !w_cnt_max) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.out       = r_out;
    assign bus.match_cnt = r_cnt;
    assign bus.cnt_sat   = w_cnt_max;
endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: three instances (overlap, no overlap,
// 2-bit counter) share one stimulus stream against a queue-based model.
module tb_seq_detector_param;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       t_in = 1'b0;
    logic       t_en = 1'b0;
    logic       t_ld = 1'b0;
    logic [5:0] t_pat = '0;
    logic       t_clr = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_detector_param_if #(.PAT_W(6), .CNT_W(8)) ifa ();
    seq_detector_param_if #(.PAT_W(6), .CNT_W(8)) ifb ();
    seq_detector_param_if #(.PAT_W(6), .CNT_W(2)) ifc ();

    assign ifa.in = t_in;
    assign ifa.en = t_en;
    assign ifa.pat_load = t_ld;
    assign ifa.pat_in = t_pat;
    assign ifa.clr_cnt = t_clr;
    assign ifb.in = t_in;
    assign ifb.en = t_en;
    assign ifb.pat_load = t_ld;
    assign ifb.pat_in = t_pat;
    assign ifb.clr_cnt = t_clr;
    assign ifc.in = t_in;
    assign ifc.en = t_en;
    assign ifc.pat_load = t_ld;
    assign ifc.pat_in = t_pat;
    assign ifc.clr_cnt = t_clr;

    seq_detector_param #(.OVERLAP(1'b1), .CNT_W(8)) u_a (
        .clk(clk), .reset(reset), .bus(ifa)
    );
    seq_detector_param #(.OVERLAP(1'b0), .CNT_W(8)) u_b (
        .clk(clk), .reset(reset), .bus(ifb)
    );
    seq_detector_param #(.OVERLAP(1'b1), .CNT_W(2)) u_c (
        .clk(clk), .reset(reset), .bus(ifc)
    );

    // Model: the bits sampled since the last restart, newest at the back.
    logic [5:0] m_pat[3];
    bit         m_q[3][$];
    int         m_cnt[3];
    int         m_out[3];
    int         m_max[3] = '{255, 255, 3};
    bit         m_ovl[3] = '{1'b1, 1'b0, 1'b1};

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d",
                     tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_pat[k] = 6'b110011;
            m_q[k].delete();
            m_cnt[k] = 0;
            m_out[k] = 0;
        end
    endtask

    task automatic model_edge();
        bit mt;
        for (int k = 0; k < 3; k++) begin
            mt = 1'b0;
            if (t_ld) begin
                m_pat[k] = t_pat;
                m_q[k].delete();
            end else if (t_en) begin
                m_q[k].push_back(t_in);
                if (m_q[k].size() > 6) void'(m_q[k].pop_front());
                if (m_q[k].size() == 6) begin
                    mt = 1'b1;
                    for (int i = 0; i < 6; i++)
                        if (m_q[k][i] != m_pat[k][5-i]) mt = 1'b0;
                end
                if (mt && !m_ovl[k]) m_q[k].delete();
            end
            m_out[k] = int'(mt);
            if (t_clr) m_cnt[k] = 0;
            else if (mt && m_cnt[k] < m_max[k]) m_cnt[k]++;
        end
    endtask

    task automatic check_all();
        chk("a_out", int'(ifa.out), m_out[0]);
        chk("a_cnt", int'(ifa.match_cnt), m_cnt[0]);
        chk("a_sat", int'(ifa.cnt_sat), int'(m_cnt[0] == 255));
        chk("b_out", int'(ifb.out), m_out[1]);
        chk("b_cnt", int'(ifb.match_cnt), m_cnt[1]);
        chk("b_sat", int'(ifb.cnt_sat), int'(m_cnt[1] == 255));
        chk("c_out", int'(ifc.out), m_out[2]);
        chk("c_cnt", int'(ifc.match_cnt), m_cnt[2]);
        chk("c_sat", int'(ifc.cnt_sat), int'(m_cnt[2] == 3));
    endtask

    task automatic cyc(input bit i, input bit e, input bit ld,
                       input logic [5:0] p, input bit clr);
        t_in = i;
        t_en = e;
        t_ld = ld;
        t_pat = p;
        t_clr = clr;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic bit_in(input bit i);
        cyc(i, 1'b1, 1'b0, 6'd0, 1'b0);
    endtask

    task automatic do_reset();
        t_in = 1'b0;
        t_en = 1'b0;
        t_ld = 1'b0;
        t_clr = 1'b0;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic stream(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) bit_in(bits[i]);
    endtask

    initial begin
        logic [5:0] rp;
        bit ld;

        // Default pattern from reset
        do_reset();
        stream(16'b11001, 5);
        chk("tp1_early", int'(ifa.out), 0);
        bit_in(1'b1);
        chk("tp1_pulse", int'(ifa.out), 1);
        chk("tp1_cnt", int'(ifa.match_cnt), 1);
        bit_in(1'b0);
        chk("tp1_one_cycle", int'(ifa.out), 0);

        // Overlap vs restart
        do_reset();
        stream(16'b1100110011, 10);
        chk("tp2_ovl_cnt", int'(ifa.match_cnt), 2);
        chk("tp2_novl_cnt", int'(ifb.match_cnt), 1);

        // en gap holds history
        do_reset();
        stream(16'b110, 3);
        for (int i = 0; i < 3; i++) begin
            cyc(1'(i), 1'b0, 1'b0, 6'd0, 1'b0);
            chk("tp3_gap_out", int'(ifa.out), 0);
        end
        stream(16'b011, 3);
        chk("tp3_pulse", int'(ifa.out), 1);
        chk("tp3_cnt", int'(ifa.match_cnt), 1);

        // All-zero pattern; load ignores in even with en=1
        do_reset();
        cyc(1'b1, 1'b1, 1'b1, 6'b000000, 1'b0);
        stream(16'b0, 5);
        chk("tp4_no_early", int'(ifa.out), 0);
        bit_in(1'b0);
        chk("tp4_pulse6", int'(ifa.out), 1);
        bit_in(1'b0);
        chk("tp4_pulse7", int'(ifa.out), 1);
        chk("tp4_novl7", int'(ifb.out), 0);

        // Reset discards partial match
        do_reset();
        stream(16'b11001, 5);
        do_reset();
        bit_in(1'b1);
        chk("tp5_no_pulse", int'(ifa.out), 0);

        // Saturation and clear-beats-match
        do_reset();
        cyc(1'b0, 1'b0, 1'b1, 6'b111111, 1'b0);
        stream(16'h1ff, 9);
        chk("tp6_c_cnt", int'(ifc.match_cnt), 3);
        chk("tp6_c_sat", int'(ifc.cnt_sat), 1);
        chk("tp6_a_cnt", int'(ifa.match_cnt), 4);
        cyc(1'b1, 1'b1, 1'b0, 6'd0, 1'b1);
        chk("tp6_clr_pulse", int'(ifa.out), 1);
        chk("tp6_clr_a", int'(ifa.match_cnt), 0);
        chk("tp6_clr_c", int'(ifc.match_cnt), 0);

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            if (n % 700 == 699) do_reset();
            ld = ($urandom_range(0, 49) == 0);
            case ($urandom_range(0, 3))
                0: rp = 6'h00;
                1: rp = 6'h3f;
                2: rp = 6'b110011;
                default: rp = 6'($urandom);
            endcase
            cyc(1'($urandom), ($urandom_range(0, 3) != 0), ld, rp,
                ($urandom_range(0, 79) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parameterised serial bit-sequence detector; the next generation of the fixed 6-bit pattern FSM in the sequential-logic library.
- Pattern width, reset-default pattern, overlap mode and match-counter width are all parameters.
- Adds a runtime pattern reload, an input-valid qualifier and a saturating match counter.
- Sits between a serial bit source and downstream control or statistics logic.

Parameters:
- PAT_W, 6, pattern length in bits (2..16)
- PATTERN, 6'b110011, reset-default pattern; MSB is the oldest bit received
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = history restarts after each match
- CNT_W, 8, width of the match counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in  in  1  serial data bit, sampled only when en=1
- en  in  1  input valid; when 0 the bit is ignored and all history is held
- pat_load  in  1  load pat_in as the new pattern
- pat_in  in  PAT_W  new pattern value
- clr_cnt  in  1  synchronous clear of match_cnt
- out  out  1  registered one-cycle match pulse
- match_cnt  out  CNT_W  saturating count of matches
- cnt_sat  out  1  high while match_cnt equals all-ones

Behaviour:
- One clock; reset is asynchronous and active-high.
- Internal state: pat_r[PAT_W], hist[PAT_W], fill (0..PAT_W).
- Reset values: pat_r=PATTERN, hist=0, fill=0, out=0, match_cnt=0, cnt_sat=0.
- Reset asserted mid-sequence discards any partial match immediately. No pulse follows deassertion until a full PAT_W bits have been received.
- Priority at each rising edge: pat_load, then en, then idle.
- pat_load=1 (pat_load beats en):
  - pat_r<=pat_in, hist<=0, fill<=0, out<=0.
  - The in bit is ignored that cycle, even when en=1.
  - match_cnt is unaffected, except by clr_cnt.
- en=1, pat_load=0:
  - hist_n = {hist[PAT_W-2:0], in}; fill_n = min(fill+1, PAT_W).
  - match = (fill_n==PAT_W) && (hist_n==pat_r).
  - hist<=hist_n; out<=match.
  - fill<=0 if (match && OVERLAP==0), else fill_n.
- en=0, pat_load=0: hist and fill are held; out<=0.
- Latency: out is high for exactly the one cycle following the edge that sampled the final pattern bit. It is never high for two consecutive cycles unless en=1 and matches occur on consecutive sampled bits. Example: an all-ones pattern in OVERLAP=1 pulses on every bit.
- A match needs PAT_W valid bits since the last reset, pattern load or (when OVERLAP=0) match. Zero-filled history never matches an all-zero pattern prematurely.
- Counter:
  - clr_cnt=1 sets match_cnt<=0; clr_cnt beats a simultaneous match.
  - Otherwise a match increments match_cnt, holding at 2^CNT_W-1 (no wrap).
  - cnt_sat is combinational from match_cnt == all-ones.
- The same-edge match is counted even when pat_load is not asserted. A pat_load cycle never produces a match.

Test Plan:
- Defaults, en=1, stream 1,1,0,0,1,1 from reset -> out=1 only in the cycle after the 6th edge; match_cnt=1.
- OVERLAP=1, stream 1,1,0,0,1,1,0,0,1,1 -> out pulses after bits 6 and 10; match_cnt=2. With OVERLAP=0, same stream -> single pulse after bit 6; match_cnt=1.
- Stream 1,1,0 with en=0 for 3 cycles, then en=1 with 0,1,1 -> exactly one pulse, after the final 1; out=0 throughout the en=0 gap.
- pat_load with pat_in=6'b000000, then 5 zeros -> no pulse; 6th zero -> pulse; a 7th zero (OVERLAP=1) -> pulse again.
- Assert reset after 1,1,0,0,1, deassert, send 1 -> no pulse. CNT_W=2, 4 matches -> match_cnt=3, cnt_sat=1. clr_cnt coincident with a match -> match_cnt=0.
